// File: rtl/hw_nios_mem_pkg.sv
// Shared definitions for the dual-port on-chip memory.
//   clog2      : ceiling log2, used to derive the default address width
//   state_e    : clear-engine FSM state
//   COLL_CNT_W : width of the saturating s2 write-collision counter
package hw_nios_mem_pkg;

    localparam int unsigned COLL_CNT_W = 16;

    typedef enum logic {
        READY = 1'b0,
        CLEAR = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/hw_nios_onchip_memory_dp_if.sv
// Avalon-MM slave bundle for one memory port.
//   address/chipselect/read/write/byteenable/writedata : command from the master
//   readdata/readdatavalid/waitrequest                  : response from the slave
interface hw_nios_onchip_memory_dp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) ();

    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );

endinterface

// File: rtl/hw_nios_tdp_ram_core.sv
// Inferred true-dual-port RAM, single clock, per-byte write enables.
//   clk_i                     : clock
//   a_addr_i/a_be_i/a_wdata_i : port A write command (be=0 means no write)
//   a_rdata_o                 : port A registered read, old data on same-address write
//   b_*                       : identical port B
module hw_nios_tdp_ram_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                    clk_i,
    input  logic [ADDR_WIDTH-1:0]   a_addr_i,
    input  logic [DATA_WIDTH/8-1:0] a_be_i,
    input  logic [DATA_WIDTH-1:0]   a_wdata_i,
    output logic [DATA_WIDTH-1:0]   a_rdata_o,
    input  logic [ADDR_WIDTH-1:0]   b_addr_i,
    input  logic [DATA_WIDTH/8-1:0] b_be_i,
    input  logic [DATA_WIDTH-1:0]   b_wdata_i,
    output logic [DATA_WIDTH-1:0]   b_rdata_o
);

    localparam int unsigned BeW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_q;

    // Reads sample the array before this edge's writes land, giving old-data behaviour.
    always_ff @(posedge clk_i) begin
        a_rdata_q <= mem[a_addr_i];
        b_rdata_q <= mem[b_addr_i];
        for (int i = 0; i < BeW; i++) begin
            if (b_be_i[i]) mem[b_addr_i][8*i +: 8] <= b_wdata_i[8*i +: 8];
            if (a_be_i[i]) mem[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/hw_nios_onchip_memory_dp.sv
// Dual-port on-chip RAM with two Avalon-MM slaves, a zero-fill clear engine and a
// saturating counter of s2 writes dropped on same-address collision with s1.
//   clk, reset      : clock, asynchronous active-high reset
//   s1, s2          : Avalon-MM slave ports
//   clear_req       : pulse to start a zero-fill
//   busy            : high while the clear engine owns the array
//   collision_count : dropped s2 writes, saturating
module hw_nios_onchip_memory_dp
    import hw_nios_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned ADDR_WIDTH     = clog2(DEPTH),
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    hw_nios_onchip_memory_dp_if.slave    s1,
    hw_nios_onchip_memory_dp_if.slave    s2,
    input  logic                         clear_req,
    output logic                         busy,
    output logic [COLL_CNT_W-1:0]        collision_count
);

    localparam int unsigned BeW        = DATA_WIDTH / 8;
    localparam state_e      ResetState = CLEAR_ON_RESET ? CLEAR : READY;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic [COLL_CNT_W-1:0]   coll_q, coll_d;
    logic                    s1_vld_q, s1_vld_d, s1_vld2_q, s1_vld2_d;
    logic                    s2_vld_q, s2_vld_d, s2_vld2_q, s2_vld2_d;
    logic [DATA_WIDTH-1:0]   s1_rd2_q, s1_rd2_d, s2_rd2_q, s2_rd2_d;

    logic                    clearing;
    logic                    acc_wr1, acc_rd1, acc_wr2, acc_rd2, collide;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [BeW-1:0]          a_be, b_be;
    logic [DATA_WIDTH-1:0]   a_wdata, a_rdata, b_rdata;

    always_comb begin
        clearing = (state_q == CLEAR);
        // A simultaneous read+write is treated as a write only.
        acc_wr1  = s1.chipselect & s1.write & ~clearing;
        acc_rd1  = s1.chipselect & s1.read & ~s1.write & ~clearing;
        acc_wr2  = s2.chipselect & s2.write & ~clearing;
        acc_rd2  = s2.chipselect & s2.read & ~s2.write & ~clearing;
        collide  = acc_wr1 & acc_wr2 & (s1.address == s2.address);
    end

    // Clear engine and collision counter
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        coll_d     = coll_q;
        case (state_q)
            READY: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d    = READY;
                    clr_addr_d = '0;
                end
            end
            default: state_d = READY;
        endcase
        if (collide && (coll_q != '1)) coll_d = coll_q + COLL_CNT_W'(1);
    end

    // Port A is shared between the clear engine and s1; port B serves s2.
    always_comb begin
        if (clearing) begin
            a_addr  = clr_addr_q;
            a_be    = '1;
            a_wdata = '0;
        end else begin
            a_addr  = s1.address;
            a_be    = acc_wr1 ? s1.byteenable : '0;
            a_wdata = s1.writedata;
        end
        b_be = (acc_wr2 && !collide) ? s2.byteenable : '0;
    end

    hw_nios_tdp_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clk),
        .a_addr_i  (a_addr),
        .a_be_i    (a_be),
        .a_wdata_i (a_wdata),
        .a_rdata_o (a_rdata),
        .b_addr_i  (s2.address),
        .b_be_i    (b_be),
        .b_wdata_i (s2.writedata),
        .b_rdata_o (b_rdata)
    );

    // Valid pipelines run independently of the FSM so in-flight reads finish during a clear.
    always_comb begin
        s1_vld_d  = acc_rd1;
        s2_vld_d  = acc_rd2;
        s1_vld2_d = s1_vld_q;
        s2_vld2_d = s2_vld_q;
        s1_rd2_d  = s1_vld_q ? a_rdata : '0;
        s2_rd2_d  = s2_vld_q ? b_rdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ResetState;
            clr_addr_q <= '0;
            coll_q     <= '0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s1_vld2_q  <= 1'b0;
            s2_vld2_q  <= 1'b0;
            s1_rd2_q   <= '0;
            s2_rd2_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            coll_q     <= coll_d;
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            s1_vld2_q  <= s1_vld2_d;
            s2_vld2_q  <= s2_vld2_d;
            s1_rd2_q   <= s1_rd2_d;
            s2_rd2_q   <= s2_rd2_d;
        end
    end

    // RAM output is masked to zero outside the valid strobe so readdata resets to 0.
    assign s1.waitrequest   = clearing;
    assign s2.waitrequest   = clearing;
    assign s1.readdatavalid = (READ_LATENCY == 2) ? s1_vld2_q : s1_vld_q;
    assign s2.readdatavalid = (READ_LATENCY == 2) ? s2_vld2_q : s2_vld_q;
    assign s1.readdata      = (READ_LATENCY == 2) ? s1_rd2_q : (s1_vld_q ? a_rdata : '0);
    assign s2.readdata      = (READ_LATENCY == 2) ? s2_rd2_q : (s2_vld_q ? b_rdata : '0);
    assign busy             = clearing;
    assign collision_count  = coll_q;

endmodule

// File: tb/tb_hw_nios_onchip_memory_dp.sv
// Directed bench for hw_nios_onchip_memory_dp: reset/clear timing, byte-enable writes,
// same-address hazards, read+write precedence and clear/reset interaction.
module tb_hw_nios_onchip_memory_dp;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;
    localparam int          RL    = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear_req = 1'b0;
    logic        busy;
    logic [15:0] coll;

    hw_nios_onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1_if ();
    hw_nios_onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s2_if ();

    hw_nios_onchip_memory_dp #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (AW),
        .READ_LATENCY   (RL),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s1              (s1_if),
        .s2              (s2_if),
        .clear_req       (clear_req),
        .busy            (busy),
        .collision_count (coll)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          op;    // 0 = write, 1 = read
        int          port;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;  // write data, or expected read data
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        s1_if.chipselect = 1'b0; s1_if.read = 1'b0; s1_if.write = 1'b0;
        s1_if.byteenable = '0;   s1_if.writedata = '0; s1_if.address = '0;
        s2_if.chipselect = 1'b0; s2_if.read = 1'b0; s2_if.write = 1'b0;
        s2_if.byteenable = '0;   s2_if.writedata = '0; s2_if.address = '0;
    endtask

    task automatic drive(input int port, input logic wr, input logic rd, input logic [9:0] addr,
                         input logic [3:0] be, input logic [31:0] d);
        if (port == 1) begin
            s1_if.chipselect = 1'b1; s1_if.write = wr; s1_if.read = rd;
            s1_if.address = addr; s1_if.byteenable = be; s1_if.writedata = d;
        end else begin
            s2_if.chipselect = 1'b1; s2_if.write = wr; s2_if.read = rd;
            s2_if.address = addr; s2_if.byteenable = be; s2_if.writedata = d;
        end
    endtask

    function automatic logic vld(input int port);
        return (port == 1) ? s1_if.readdatavalid : s2_if.readdatavalid;
    endfunction

    // Called one negedge after the command; lat counts negedges from the command negedge.
    task automatic wait_valid(input int port, output int lat, output logic [31:0] d);
        lat = 1;
        while (!vld(port) && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        d = (port == 1) ? s1_if.readdata : s2_if.readdata;
    endtask

    task automatic do_write(input int port, input logic [9:0] addr, input logic [3:0] be,
                            input logic [31:0] d);
        drive(port, 1'b1, 1'b0, addr, be, d);
        @(negedge clk);
        idle();
    endtask

    task automatic do_read(input int port, input logic [9:0] addr, input logic [31:0] exp,
                           input string name);
        int          lat;
        logic [31:0] d;
        drive(port, 1'b0, 1'b1, addr, 4'h0, 32'h0);
        @(negedge clk);
        idle();
        wait_valid(port, lat, d);
        chk({name, "_lat"}, lat, RL);
        chk({name, "_data"}, d, exp);
    endtask

    // Counts consecutive busy negedges; optionally pulses clear_req at count pulse_at.
    task automatic count_busy(input int stop_at, input int pulse_at, output int n);
        n = 0;
        while (busy && n < 2000 && n != stop_at) begin
            n++;
            clear_req = (n == pulse_at);
            @(negedge clk);
        end
        clear_req = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          lat;
        logic [31:0] d;
        logic        seen;

        vecs[0]  = '{1, 1, 10'd0,    4'h0, 32'h0000_0000};
        vecs[1]  = '{1, 2, 10'd1023, 4'h0, 32'h0000_0000};
        vecs[2]  = '{0, 1, 10'd5,    4'h5, 32'hDEAD_BEEF};
        vecs[3]  = '{1, 1, 10'd5,    4'h0, 32'h00AD_00EF};
        vecs[4]  = '{0, 2, 10'd5,    4'hA, 32'h1234_5678};
        vecs[5]  = '{1, 2, 10'd5,    4'h0, 32'h12AD_56EF};
        vecs[6]  = '{1, 1, 10'd5,    4'h0, 32'h12AD_56EF};
        vecs[7]  = '{0, 1, 10'd1023, 4'hF, 32'hFFFF_FFFF};
        vecs[8]  = '{1, 2, 10'd1023, 4'h0, 32'hFFFF_FFFF};
        vecs[9]  = '{0, 2, 10'd0,    4'h8, 32'hCAFE_F00D};
        vecs[10] = '{1, 1, 10'd0,    4'h0, 32'hCA00_0000};
        vecs[11] = '{0, 1, 10'd3,    4'hF, 32'hA5A5_A5A5};
        vecs[12] = '{1, 2, 10'd3,    4'h0, 32'hA5A5_A5A5};
        vecs[13] = '{0, 2, 10'd1,    4'h0, 32'hFFFF_FFFF};
        vecs[14] = '{1, 1, 10'd1,    4'h0, 32'h0000_0000};

        idle();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 1);
        chk("rst_s1_wait", s1_if.waitrequest, 1);
        chk("rst_s2_wait", s2_if.waitrequest, 1);
        chk("rst_s1_vld", s1_if.readdatavalid, 0);
        chk("rst_s1_rdata", s1_if.readdata, 0);
        chk("rst_s2_vld", s2_if.readdatavalid, 0);
        chk("rst_coll", coll, 0);

        // Clear on reset release
        reset = 1'b0;
        count_busy(-1, -1, n);
        chk("clear_len_reset", n, DEPTH);
        chk("ready_busy", busy, 0);
        chk("ready_s1_wait", s1_if.waitrequest, 0);
        chk("ready_s2_wait", s2_if.waitrequest, 0);

        // Table-driven writes and reads
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].op == 0) begin
                do_write(vecs[i].port, vecs[i].addr, vecs[i].be, vecs[i].data);
            end else begin
                do_read(vecs[i].port, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
            end
        end

        // Same-address write collision: s1 wins, counter increments
        drive(1, 1'b1, 1'b0, 10'd7, 4'hF, 32'h1111_1111);
        drive(2, 1'b1, 1'b0, 10'd7, 4'hF, 32'h2222_2222);
        @(negedge clk);
        idle();
        chk("coll_count1", coll, 1);
        do_read(2, 10'd7, 32'h1111_1111, "coll_rd7");

        // Simultaneous writes to different addresses both land, no count
        drive(1, 1'b1, 1'b0, 10'd8, 4'hF, 32'h3333_3333);
        drive(2, 1'b1, 1'b0, 10'd9, 4'hF, 32'h4444_4444);
        @(negedge clk);
        idle();
        chk("nocoll_count", coll, 1);
        do_read(1, 10'd8, 32'h3333_3333, "nocoll_rd8");
        do_read(2, 10'd9, 32'h4444_4444, "nocoll_rd9");

        // s1 write vs s2 read, same address: old data returned
        drive(1, 1'b1, 1'b0, 10'd3, 4'hF, 32'h5A5A_5A5A);
        drive(2, 1'b0, 1'b1, 10'd3, 4'h0, 32'h0);
        @(negedge clk);
        idle();
        wait_valid(2, lat, d);
        chk("rdw_lat", lat, RL);
        chk("rdw_old", d, 32'hA5A5_A5A5);
        do_read(1, 10'd3, 32'h5A5A_5A5A, "rdw_new");

        // read and write together: write wins, no valid
        drive(1, 1'b1, 1'b1, 10'd9, 4'hF, 32'h0F0F_0F0F);
        @(negedge clk);
        idle();
        seen = 1'b0;
        repeat (4) begin
            if (s1_if.readdatavalid) seen = 1'b1;
            @(negedge clk);
        end
        chk("rw_no_valid", seen, 0);
        do_read(1, 10'd9, 32'h0F0F_0F0F, "rw_data");

        // Clear request with reads in flight on both ports
        drive(1, 1'b0, 1'b1, 10'd3, 4'h0, 32'h0);
        drive(2, 1'b0, 1'b1, 10'd7, 4'h0, 32'h0);
        clear_req = 1'b1;
        @(negedge clk);
        idle();
        clear_req = 1'b0;
        chk("inflight_s1_vld", s1_if.readdatavalid, 1);
        chk("inflight_s1_data", s1_if.readdata, 32'h5A5A_5A5A);
        chk("inflight_s2_vld", s2_if.readdatavalid, 1);
        chk("inflight_s2_data", s2_if.readdata, 32'h1111_1111);
        chk("clr_busy", busy, 1);
        chk("clr_s1_wait", s1_if.waitrequest, 1);
        chk("clr_s2_wait", s2_if.waitrequest, 1);

        // Reset at clear cycle 500 restarts a full-length clear
        count_busy(500, -1, n);
        chk("clr_reach_500", n, 500);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 1);
        chk("midrst_coll", coll, 0);
        @(negedge clk);
        reset = 1'b0;
        // clear_req pulsed during the clear must be ignored
        count_busy(-1, 200, n);
        chk("clear_len_restart", n, DEPTH);
        chk("post_busy", busy, 0);
        chk("post_s1_wait", s1_if.waitrequest, 0);
        do_read(1, 10'd3, 32'h0, "post_rd3");
        do_read(2, 10'd7, 32'h0, "post_rd7");
        do_read(1, 10'd1023, 32'h0, "post_rd1023");
        do_read(2, 10'd5, 32'h0, "post_rd5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
